// File: rtl/irq_source_ctrl.sv
// Machine-interrupt pending source: 64-bit timer/compare, software IRQ, six external lines.
// Latency: bus access completes one cycle after sel; mip_in is registered 1 cycle after its source state.
// Backpressure: none; ready pulses one cycle per access, so the master must drop sel after ready.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ext_irq[5:0]        : external lines (synchronous to clk)
//   sel/we/addr/wdata   : register bus request; rdata/ready : response
//   irq_ack/ack_code    : core trap-taken acknowledge, retires edge-captured pending bits
//   mip_in[31:0]        : pending vector to the CSR block
module irq_source_ctrl #(
  parameter int          PRESCALE  = 1,
  parameter logic [5:0]  EDGE_MASK = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  ext_irq,
  input  logic        sel,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  input  logic        irq_ack,
  input  logic [4:0]  ack_code,
  output logic [31:0] mip_in
);

  localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(PRESCALE - 1);

  logic          r_ready;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mip;
  logic [PW-1:0] r_pre;
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic          r_msip;
  logic [5:0]    r_en;
  logic [5:0]    r_pend;
  logic [5:0]    r_prev;

  logic          w_acc;
  logic          w_wr;
  logic          w_tick;
  logic          w_mtip;
  logic [5:0]    w_rise;
  logic [5:0]    w_ack_clr;
  logic [5:0]    w_w1c;
  logic [5:0]    w_clr;
  logic [5:0]    w_pend_nxt;
  logic [5:0]    w_ext_m;
  logic [31:0]   w_rd;

  // An access is accepted on the first cycle sel is seen; the ready cycle that
  // follows blocks a second acceptance of the same held request.
  assign w_acc  = sel & ~r_ready;
  assign w_wr   = w_acc & we;
  assign w_tick = (r_pre == PRE_MAX);
  assign w_mtip = (r_mtime >= r_mtimecmp);
  assign w_rise = ext_irq & ~r_prev;

  // Trap int_code -> external line index; codes for msip/mtip or >7 map to nothing.
  always_comb begin
    w_ack_clr = 6'b000000;
    if (irq_ack) begin
      case (ack_code)
        5'd0:    w_ack_clr = 6'b000001;
        5'd1:    w_ack_clr = 6'b000010;
        5'd2:    w_ack_clr = 6'b000100;
        5'd4:    w_ack_clr = 6'b001000;
        5'd5:    w_ack_clr = 6'b010000;
        5'd6:    w_ack_clr = 6'b100000;
        default: w_ack_clr = 6'b000000;
      endcase
    end
  end

  assign w_w1c = (w_wr && addr == 3'd5) ? wdata[5:0] : 6'b000000;
  assign w_clr = (w_ack_clr | w_w1c) & EDGE_MASK;

  // Edge lines: set beats clear. Level lines simply track the input.
  assign w_pend_nxt = (EDGE_MASK & (w_rise | (r_pend & ~w_clr))) | (~EDGE_MASK & ext_irq);

  assign w_ext_m = r_pend & r_en;

  always_comb begin
    w_rd = 32'h0;
    case (addr)
      3'd0:    w_rd = {31'h0, r_msip};
      3'd1:    w_rd = r_mtime[31:0];
      3'd2:    w_rd = r_mtime[63:32];
      3'd3:    w_rd = r_mtimecmp[31:0];
      3'd4:    w_rd = r_mtimecmp[63:32];
      3'd5:    w_rd = {26'h0, r_pend};
      3'd6:    w_rd = {26'h0, r_en};
      default: w_rd = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready    <= 1'b0;
      r_rdata    <= 32'h0;
      r_mip      <= 32'h0;
      r_pre      <= '0;
      r_mtime    <= 64'h0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_msip     <= 1'b0;
      r_en       <= 6'h0;
      r_pend     <= 6'h0;
      r_prev     <= 6'h0;
    end else begin
      r_ready <= w_acc;
      if (w_acc) r_rdata <= w_rd;

      r_pre <= w_tick ? '0 : r_pre + 1'b1;

      // A bus write to either mtime half takes priority over the tick.
      if (w_wr && addr == 3'd1)      r_mtime[31:0]  <= wdata;
      else if (w_wr && addr == 3'd2) r_mtime[63:32] <= wdata;
      else if (w_tick)               r_mtime        <= r_mtime + 64'd1;

      if (w_wr && addr == 3'd3) r_mtimecmp[31:0]  <= wdata;
      if (w_wr && addr == 3'd4) r_mtimecmp[63:32] <= wdata;
      if (w_wr && addr == 3'd0) r_msip            <= wdata[0];
      if (w_wr && addr == 3'd6) r_en              <= wdata[5:0];

      r_prev <= ext_irq;
      r_pend <= w_pend_nxt;

      r_mip <= {24'h0, w_mtip, w_ext_m[5:3], r_msip, w_ext_m[2:0]};
    end
  end

  assign ready  = r_ready;
  assign rdata  = r_rdata;
  assign mip_in = r_mip;

endmodule

// File: tb/tb_irq_source_ctrl.sv
module tb_irq_source_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  ext_irq;
  logic        sel;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        irq_ack;
  logic [4:0]  ack_code;
  logic [31:0] mip_in;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  irq_source_ctrl #(.PRESCALE(1), .EDGE_MASK(6'b000001)) dut (
    .clk(clk), .reset(reset), .ext_irq(ext_irq), .sel(sel), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .irq_ack(irq_ack), .ack_code(ack_code), .mip_in(mip_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every read completion pops the expected value queued at issue.
  always @(negedge clk) begin
    if (ready === 1'b1 && we === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %h expected no response", rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h", rdata, e);
        end
      end
    end
  end

  task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d, input logic [31:0] e);
    int n;
    @(posedge clk); #1;
    sel = 1'b1; we = w; addr = a; wdata = d;
    if (!w) exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready !== 1'b1 && n < 6);
    chk("ready_lat", 32'(n), 32'd2);
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("ready_pulse", {31'h0, ready}, 32'h0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 32'h0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e);
    bus(1'b0, a, 32'h0, e);
  endtask

  task automatic drv_ext(input logic [5:0] x, input logic ack, input logic [4:0] code);
    @(posedge clk); #1;
    ext_irq = x; irq_ack = ack; ack_code = code;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    reset = 1'b1; ext_irq = 6'h0; sel = 1'b0; we = 1'b0; addr = 3'd0;
    wdata = 32'h0; irq_ack = 1'b0; ack_code = 5'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mip", mip_in, 32'h0);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);

    rd(3'd3, 32'hFFFF_FFFF);
    rd(3'd4, 32'hFFFF_FFFF);
    rd(3'd7, 32'h0);
    rd(3'd6, 32'h0);

    // Timer compare: mtime restarts at 0, compare at 40.
    wr(3'd4, 32'h0);
    wr(3'd1, 32'h0);
    wr(3'd3, 32'd40);
    j = 0;
    while (mip_in[7] !== 1'b1 && j < 100) begin
      @(negedge clk);
      j++;
    end
    chk("mtip_rise", 32'(j), 32'd37);
    chk("mtip_vec", mip_in, 32'h80);
    wr(3'd3, 32'hFFFF_FFFF);
    chk("mtip_clear", mip_in, 32'h0);

    // Software interrupt.
    wr(3'd0, 32'h1);
    chk("msip_set", mip_in, 32'h8);
    rd(3'd0, 32'h1);
    wr(3'd0, 32'h0);
    chk("msip_clr", mip_in, 32'h0);

    // Edge line 0.
    wr(3'd6, 32'h3F);
    chk("ext_idle", mip_in, 32'h0);
    drv_ext(6'h01, 1'b0, 5'd0);
    drv_ext(6'h00, 1'b0, 5'd0);
    repeat (3) @(negedge clk);
    chk("edge_hold", mip_in, 32'h1);
    rd(3'd5, 32'h1);
    drv_ext(6'h00, 1'b1, 5'd3);
    drv_ext(6'h00, 1'b1, 5'd9);
    drv_ext(6'h00, 1'b1, 5'd7);
    drv_ext(6'h00, 1'b0, 5'd0);
    repeat (3) @(negedge clk);
    chk("ack_unmapped", mip_in, 32'h1);
    drv_ext(6'h00, 1'b1, 5'd0);
    drv_ext(6'h00, 1'b0, 5'd0);
    repeat (3) @(negedge clk);
    chk("ack_clear", mip_in, 32'h0);
    drv_ext(6'h01, 1'b0, 5'd0);
    drv_ext(6'h00, 1'b0, 5'd0);
    repeat (3) @(negedge clk);
    chk("edge_again", mip_in, 32'h1);
    drv_ext(6'h01, 1'b1, 5'd0);
    drv_ext(6'h00, 1'b0, 5'd0);
    repeat (3) @(negedge clk);
    chk("set_wins", mip_in, 32'h1);
    wr(3'd5, 32'h1);
    chk("w1c_clear", mip_in, 32'h0);

    // Level line 3 -> mip bit 4, masked by enable only at the output.
    drv_ext(6'h08, 1'b0, 5'd0);
    repeat (3) @(negedge clk);
    chk("level_on", mip_in, 32'h10);
    rd(3'd5, 32'h08);
    wr(3'd6, 32'h0);
    chk("level_masked", mip_in, 32'h0);
    rd(3'd5, 32'h08);
    drv_ext(6'h00, 1'b0, 5'd0);

    // Rollover and write-over-increment.
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd1, 32'hFFFF_FFFE);
    rd(3'd1, 32'h0);
    rd(3'd2, 32'h0);
    wr(3'd1, 32'h0000_1234);
    rd(3'd1, 32'h0000_1236);

    // Reset arriving together with a write access.
    wr(3'd0, 32'h1);
    chk("pre_rst_msip", mip_in, 32'h8);
    @(posedge clk); #1;
    sel = 1'b1; we = 1'b1; addr = 3'd0; wdata = 32'h1; reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_ready", {31'h0, ready}, 32'h0);
    chk("midrst_mip", mip_in, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; reset = 1'b0;
    rd(3'd0, 32'h0);
    rd(3'd3, 32'hFFFF_FFFF);

    repeat (2) @(negedge clk);
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
